led_frame_scanner: RTL and testbench
====================================

# led_frame_scanner

Upstream feeder for the LED panel shift-register chain (`TopLevel`). It holds a double-buffered frame of DEPTH entries; each entry is one 128-bit word split into `rA`..`rD`. It presents the entries to the panel one at a time. For each entry it blanks the panel (`OE`=1) while the chain shifts in the new data, then enables the panel (`OE`=0) for a fixed dwell. The host writes into the back bank and requests a swap, which takes effect only on a frame boundary, so the displayed frame never tears.

## Interface
- `DEPTH`, 4: entries per frame, ≥1.
- `BLANK_CYCLES`, 37: `OE`=1 cycles after each load; covers chain shift time; ≥1.
- `DWELL_CYCLES`, 37: `OE`=0 cycles per entry; ≥1.
- `AW`, `$clog2(DEPTH)` (min 1): address width, derived.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, synchronous, active-low.
- `en` in 1: scan enable.
- `wr_en` in 1: write strobe to the back bank.
- `wr_addr` in AW: entry index to write.
- `wr_data` in 128: entry data; [31:0]→`rA`, [63:32]→`rB`, [95:64]→`rC`, [127:96]→`rD`.
- `swap_req` in 1: 1-cycle pulse; requests a bank swap.
- `rA`,`rB`,`rC`,`rD` out 32 each: data words to `TopLevel`.
- `OE` out 1: panel output enable, active-low.
- `row_idx` out AW: entry currently presented.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: 1-cycle pulse at the end of the last entry.
- `swap_ack` out 1: 1-cycle pulse on the cycle the bank select toggles.

## Operation
- Storage is two banks of DEPTH×128 bits. The `front` register selects the displayed bank; the back bank is `!front`. Memory contents are not reset.
- A write with `wr_en`=1 stores into the back bank as seen by the current `front` value. If a write occurs in the swap cycle, it lands in the pre-swap back bank, which becomes the new front.
- `pending` is set by `swap_req` and cleared by a swap. A `swap_req` arriving in the swap cycle is consumed by that swap, so no second swap follows.
- State machine:
  - IDLE: if `en`=1, go to LOAD. If `pending`=1 on this transition, swap first (toggle `front`, pulse `swap_ack`).
  - LOAD (1 cycle): read `row_idx` from the front bank; `rA`..`rD` take the values on exit. Go to BLANK.
  - BLANK (`BLANK_CYCLES`): go to SHOW.
  - SHOW (`DWELL_CYCLES`): on the last cycle:
    - If `row_idx`=DEPTH-1: wrap to 0, pulse `frame_done`, and swap if `pending`=1.
    - Otherwise increment `row_idx`.
    - Then, if `en`=1, go to LOAD; if `en`=0, go to IDLE.
- `en` deasserted mid-entry: the current BLANK/SHOW completes; the block leaves SHOW to IDLE and drops no partial dwell.
- Entering IDLE: `rA`..`rD` cleared to 0 and `row_idx`=0. A pending swap is held.
- `OE` decodes the state register: 0 only in SHOW.
- Dwell/blank counter: one down-counter, width `$clog2(max(BLANK_CYCLES,DWELL_CYCLES)+1)`, reloaded on every state change.

## Timing
- Reset (`rst`=0 at an edge) values: state IDLE, `OE`=1, `rA`..`rD`=0, `row_idx`=0, `front`=0, `pending`=0, `busy`=0, `frame_done`=0, `swap_ack`=0. Reset overrides every state, mid-operation included.
- Latency from `en` sampled high in IDLE:
  - LOAD on the next cycle.
  - New `rA`..`rD` visible 2 edges after `en` is sampled.
  - `OE` falls 1+`BLANK_CYCLES` cycles after LOAD.
- Entry period: 1+`BLANK_CYCLES`+`DWELL_CYCLES` cycles (75 with defaults). Frame period: DEPTH×75 (300).
- `frame_done` and a frame-boundary `swap_ack` are coincident on the final SHOW cycle. The following LOAD reads entry 0 of the new front bank.
- `rA`..`rD` change only on the LOAD exit edge or on IDLE entry, never while `OE`=0.

## Test plan
- Reset: hold `rst`=0 for 2 cycles during SHOW → next cycle `OE`=1, `rA`..`rD`=0, `row_idx`=0, `busy`=0, and no pulses.
- Fill and start:
  - Stimulus: in IDLE, write entries 0..3 with `rA`..`rD`=32'b1011 + index; pulse `swap_req`; then assert `en`.
  - Required: `swap_ack` pulses on the IDLE→LOAD cycle; `rA`=32'b1011 two edges after `en` is sampled; `OE`=0 38 cycles later for exactly 37 cycles.
- Wrap: run 4 entries → `row_idx` sequence 0,1,2,3,0; `frame_done` pulses once every 300 cycles, on the last cycle of entry 3.
- Mid-frame swap:
  - Stimulus: write new data, then pulse `swap_req` while entry 1 is displayed.
  - Required: displayed data is unchanged through entry 3; `swap_ack` coincides with `frame_done`; entry 0 shows the new data.
- Coincident events:
  - Stimulus: pulse `swap_req` and `wr_en` in the swap cycle.
  - Required: exactly one swap; the write appears in the new front bank; no swap at the next boundary.
- Enable drop: deassert `en` mid-BLANK → BLANK and SHOW complete (`OE`=0 for 37 cycles), then IDLE, with `OE`=1, `rA`..`rD`=0 and `row_idx`=0.

Source files
------------

// File: rtl/led_frame_scanner.sv
// Purpose : double-buffered LED frame feeder; per entry LOAD -> BLANK (OE=1) -> SHOW (OE=0).
// Latency : rA..rD valid on the LOAD exit edge; OE falls 1+BLANK_CYCLES cycles after LOAD.
// Backpr. : none; host writes and swap requests are always accepted (swap deferred to frame end).
// Ports   : clk/rst (sync, active-low); en scan enable; wr_en/wr_addr/wr_data write the back bank;
//           swap_req requests a bank swap; rA..rD panel data; OE active-low enable; row_idx entry
//           index; busy = not idle; frame_done / swap_ack single-cycle pulses.
module led_frame_scanner #(
  parameter int DEPTH        = 4,
  parameter int BLANK_CYCLES = 37,
  parameter int DWELL_CYCLES = 37,
  parameter int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [127:0]  wr_data,
  input  logic          swap_req,
  output logic [31:0]   rA,
  output logic [31:0]   rB,
  output logic [31:0]   rC,
  output logic [31:0]   rD,
  output logic          OE,
  output logic [AW-1:0] row_idx,
  output logic          busy,
  output logic          frame_done,
  output logic          swap_ack
);

  localparam int MAXC = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BLANK, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic            front_q, front_d;
  logic            pending_q, pending_d;
  logic [127:0]    data_q, data_d;
  logic            swap;
  logic            frame_end;
  logic            cnt_zero;

  // Two banks; not reset. Writes always target the bank that is "back" right now,
  // so a write in the swap cycle lands in the bank that is about to become front.
  logic [127:0]    bank_mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[~front_q][wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    front_d   = front_q;
    pending_d = pending_q;
    data_d    = data_q;
    swap      = 1'b0;
    frame_end = 1'b0;
    cnt_zero  = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
          swap    = pending_q;
        end
      end
      ST_LOAD: begin
        // front_q already reflects any swap taken on the way into LOAD.
        data_d  = bank_mem[front_q][row_idx_q];
        state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt_zero) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_zero) begin
          if (row_idx_q == AW'(DEPTH - 1)) begin
            row_idx_d = '0;
            frame_end = 1'b1;
            swap      = pending_q;
          end else begin
            row_idx_d = row_idx_q + AW'(1);
          end
          state_d = en ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Going idle blanks the data bus and rewinds to entry 0; a pending swap survives.
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      data_d    = '0;
      row_idx_d = '0;
    end

    // The counter holds "cycles left after this one" in the current state.
    if (state_d != state_q) begin
      case (state_d)
        ST_BLANK: cnt_d = CW'(BLANK_CYCLES - 1);
        ST_SHOW:  cnt_d = CW'(DWELL_CYCLES - 1);
        default:  cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - CW'(1);
    end

    // A request arriving in the swap cycle is absorbed by that swap.
    if (swap) begin
      front_d   = ~front_q;
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_idx_q <= '0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_idx_q <= row_idx_d;
      front_q   <= front_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign rA         = data_q[31:0];
  assign rB         = data_q[63:32];
  assign rC         = data_q[95:64];
  assign rD         = data_q[127:96];
  assign OE         = (state_q != ST_SHOW);
  assign busy       = (state_q != ST_IDLE);
  assign row_idx    = row_idx_q;
  // Pulses are suppressed while reset is asserted so nothing escapes the reset cycle.
  assign frame_done = frame_end & rst;
  assign swap_ack   = swap & rst;

endmodule

// File: tb/tb_led_frame_scanner.sv
module tb_led_frame_scanner;

  localparam int DEPTH = 4;
  localparam int BLANK = 37;
  localparam int DWELL = 37;
  localparam int AW    = 2;
  localparam int PER   = 1 + BLANK + DWELL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [127:0]  wr_data = '0;
  logic          swap_req = 1'b0;
  logic [31:0]   rA, rB, rC, rD;
  logic          oe;
  logic [AW-1:0] row_idx;
  logic          busy, frame_done, swap_ack;
  wire  [127:0]  data = {rD, rC, rB, rA};

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] fill_data [DEPTH];
  logic [127:0] new_data  [DEPTH];
  logic [127:0] coin_data [DEPTH];
  logic [127:0] xval;

  led_frame_scanner #(.DEPTH(DEPTH), .BLANK_CYCLES(BLANK), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .rA(rA), .rB(rB), .rC(rC), .rD(rD), .OE(oe), .row_idx(row_idx),
    .busy(busy), .frame_done(frame_done), .swap_ack(swap_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: an entry is a PER-cycle window; phase 0 is the load slot,
  // phases 1..BLANK are blanked, the remaining phases are lit.
  typedef struct {
    bit           active;
    int           phase;
    int           row;
    bit           front;
    bit           pending;
    logic [127:0] data;
  } model_t;

  model_t       m;
  logic [127:0] m_mem [2][DEPTH];

  function automatic model_t next_model(input model_t c, input logic r, input logic e, input logic sr);
    model_t n;
    bit     sw;
    n  = c;
    sw = 1'b0;
    if (!r) begin
      n.active = 1'b0; n.phase = 0; n.row = 0; n.front = 1'b0; n.pending = 1'b0; n.data = '0;
      return n;
    end
    if (!c.active) begin
      if (e) begin
        n.active = 1'b1;
        n.phase  = 0;
        sw       = c.pending;
      end
    end else if (c.phase == PER - 1) begin
      if (c.row == DEPTH - 1) begin
        n.row = 0;
        sw    = c.pending;
      end else begin
        n.row = c.row + 1;
      end
      n.phase = 0;
      if (!e) begin
        n.active = 1'b0;
        n.row    = 0;
        n.data   = '0;
      end
    end else begin
      if (c.phase == 0) n.data = m_mem[c.front ? 1 : 0][c.row];
      n.phase = c.phase + 1;
    end
    if (sw) begin
      n.front   = ~c.front;
      n.pending = 1'b0;
    end else if (sr) begin
      n.pending = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= next_model(m, rst, en, swap_req);
    if (wr_en) m_mem[m.front ? 0 : 1][wr_addr] <= wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [127:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_fd(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (frame_done === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (oe !== 1'b1 || busy !== 1'b0 || row_idx !== '0 || data !== '0 ||
        frame_done !== 1'b0 || swap_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: oe=%b busy=%b row=%0d data=%h fd=%b sa=%b, required oe=1 busy=0 row=0 data=0 fd=0 sa=0",
               oe, busy, row_idx, data, frame_done, swap_ack);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_start();
    int bad;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      fill_data[i] = {4{32'd11 + 32'(i)}};
      write_entry(i, fill_data[i]);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    en = 1'b1;
    #1;
    n_checks++;
    if (swap_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL start_swap_ack: got %b, required 1 on IDLE->LOAD cycle", swap_ack);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || data !== '0 || swap_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL load_cycle: busy=%b data=%h sa=%b, required busy=1 data=0 sa=0", busy, data, swap_ack);
    end
    tick();
    n_checks++;
    if (rA !== 32'd11 || data !== fill_data[0] || oe !== 1'b1) begin
      n_errors++;
      $display("FAIL first_data: rA=%h data=%h oe=%b, required rA=0000000b data=%h oe=1", rA, data, oe, fill_data[0]);
    end
    bad = 0;
    for (int k = 2; k <= 37; k++) begin
      tick();
      if (oe !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL blank_window: %0d lit cycles before edge 38, required 0", bad);
    end
    tick();
    n_checks++;
    if (oe !== 1'b0) begin
      n_errors++;
      $display("FAIL oe_fall: oe=%b 38 edges after en, required 0", oe);
    end
    n = 0;
    while (oe === 1'b0 && n < 100) begin
      n++;
      tick();
    end
    n_checks++;
    if (n != DWELL) begin
      n_errors++;
      $display("FAIL dwell_len: OE low for %0d cycles, required %0d", n, DWELL);
    end
  endtask

  task automatic test_wrap();
    int fd_at[$];
    int rows[$];
    int bad;
    int start;
    int diff;
    logic [AW-1:0] prev;
    prev  = row_idx;
    start = int'(row_idx);
    bad   = 0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (row_idx !== prev) begin
        rows.push_back(int'(row_idx));
        prev = row_idx;
      end
      if (frame_done === 1'b1) begin
        fd_at.push_back(i);
        if (row_idx !== AW'(DEPTH - 1) || oe !== 1'b0) bad++;
      end
    end
    diff = (fd_at.size() >= 2) ? fd_at[1] - fd_at[0] : -1;
    n_checks++;
    if (fd_at.size() != 2 || diff != DEPTH * PER) begin
      n_errors++;
      $display("FAIL frame_period: %0d pulses spaced %0d, required 2 spaced %0d", fd_at.size(), diff, DEPTH * PER);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL frame_done_pos: %0d pulses off the last lit cycle of entry 3, required 0", bad);
    end
    for (int k = 0; k < rows.size(); k++) begin
      if (rows[k] != (start + 1 + k) % DEPTH) bad++;
    end
    n_checks++;
    if (bad != 0 || rows.size() < 5) begin
      n_errors++;
      $display("FAIL row_sequence: %0d bad of %0d transitions, required 0 bad and at least 5", bad, rows.size());
    end
  endtask

  task automatic test_midframe_swap();
    bit ok;
    bit hit;
    int bad;
    wait_fd(400, ok);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      new_data[i] = {$urandom, $urandom, $urandom, $urandom};
      write_entry(i, new_data[i]);
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (row_idx === AW'(1)) ok = 1'b1;
      else tick();
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL wait_row1: row_idx=%0d after 200 cycles, required 1", row_idx);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    bad = 0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (oe === 1'b0 && data !== fill_data[row_idx]) bad++;
      if (frame_done === 1'b1) hit = 1'b1;
      else tick();
    end
    n_checks++;
    if (bad != 0 || !hit) begin
      n_errors++;
      $display("FAIL mid_hold: %0d lit cycles with changed data, boundary seen=%b, required 0 and 1", bad, hit);
    end
    n_checks++;
    if (swap_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL boundary_swap_ack: got %b with frame_done, required 1", swap_ack);
    end
    tick();
    tick();
    n_checks++;
    if (data !== new_data[0] || row_idx !== '0) begin
      n_errors++;
      $display("FAIL new_front_entry0: data=%h row=%0d, required %h row 0", data, row_idx, new_data[0]);
    end
  endtask

  task automatic test_coincident();
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin
      coin_data[i] = {$urandom, $urandom, $urandom, $urandom};
      write_entry(i, coin_data[i]);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wait_fd(400, ok);
    xval     = {$urandom, $urandom, $urandom, $urandom};
    swap_req = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = '0;
    wr_data  = xval;
    #1;
    n_checks++;
    if (!ok || swap_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL coin_swap: boundary=%b swap_ack=%b, required 1 and 1", ok, swap_ack);
    end
    tick();
    swap_req = 1'b0;
    wr_en    = 1'b0;
    tick();
    n_checks++;
    if (data !== xval) begin
      n_errors++;
      $display("FAIL coin_write: data=%h, required %h", data, xval);
    end
    wait_fd(400, ok);
    n_checks++;
    if (!ok || swap_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL coin_no_second_swap: boundary=%b swap_ack=%b, required 1 and 0", ok, swap_ack);
    end
    tick();
    tick();
    n_checks++;
    if (data !== xval) begin
      n_errors++;
      $display("FAIL coin_same_bank: data=%h, required %h", data, xval);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    int bad;
    en = 1'b0;
    n  = 0;
    while (oe !== 1'b0 && n < 100) begin
      n++;
      tick();
    end
    n   = 0;
    bad = 0;
    while (oe === 1'b0 && n < 100) begin
      if (data !== xval) bad++;
      n++;
      tick();
    end
    n_checks++;
    if (n != DWELL || bad != 0) begin
      n_errors++;
      $display("FAIL drop_dwell: lit %0d cycles, %0d bad data, required %0d and 0", n, bad, DWELL);
    end
    n_checks++;
    if (busy !== 1'b0 || oe !== 1'b1 || data !== '0 || row_idx !== '0) begin
      n_errors++;
      $display("FAIL drop_idle: busy=%b oe=%b data=%h row=%0d, required 0 1 0 0", busy, oe, data, row_idx);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    en = 1'b1;
    n  = 0;
    while (oe !== 1'b0 && n < 100) begin
      n++;
      tick();
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (oe !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_setup: oe=%b before reset, required 0", oe);
    end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (oe !== 1'b1 || busy !== 1'b0 || row_idx !== '0 || data !== '0 ||
        frame_done !== 1'b0 || swap_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid: oe=%b busy=%b row=%0d data=%h fd=%b sa=%b, required 1 0 0 0 0 0",
               oe, busy, row_idx, data, frame_done, swap_ack);
    end
  endtask

  task automatic test_random();
    int   printed;
    logic exp_oe, exp_fd, exp_sa;
    printed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      swap_req = ($urandom_range(0, 149) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      #3;
      exp_oe = !(m.active && m.phase >= 1 + BLANK);
      exp_fd = rst && m.active && (m.phase == PER - 1) && (m.row == DEPTH - 1);
      exp_sa = rst && m.pending && ((!m.active && en) || exp_fd);
      n_checks++;
      if (oe !== exp_oe || busy !== m.active || frame_done !== exp_fd || swap_ack !== exp_sa) begin
        n_errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL rand_ctrl cyc %0d: oe=%b busy=%b fd=%b sa=%b, required %b %b %b %b",
                   i, oe, busy, frame_done, swap_ack, exp_oe, m.active, exp_fd, exp_sa);
        end
      end
      n_checks++;
      if (row_idx !== AW'(m.row) || data !== m.data) begin
        n_errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL rand_data cyc %0d: row=%0d data=%h, required row=%0d data=%h",
                   i, row_idx, data, m.row, m.data);
        end
      end
      @(posedge clk);
      #1;
    end
    swap_req = 1'b0;
    wr_en    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_start();
    test_wrap();
    test_midframe_swap();
    test_coincident();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
